jtframe_scanhalf: RTL and testbench

// Line halver, the inverse of the codebase's scan doubler: takes a pixel stream at double rate
// (basex2_cen, 31kHz-style lines) and emits a base-rate stream (base_cen, 15kHz-style lines).

---
 rtl/jtframe_scanhalf.sv | 163 ++++++++++++++++
 tb/tb_jtframe_scanhalf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jtframe_scanhalf.sv
// jtframe_scanhalf
// Line halver: accepts a double-rate pixel stream (basex2_cen, 31kHz-style lines)
// and emits a base-rate stream (base_cen, 15kHz-style lines). Each output line is
// built from a pair of input lines: either the first line alone (blend_en=0) or a
// per-channel average of both lines (blend_en=1).
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   base_cen     output pixel strobe (base rate)
//   basex2_cen   input pixel strobe (2x base rate)
//   blend_en     1: average line pairs, 0: keep first line of each pair
//   x2_lstart    optional input line-start marker, qualified by basex2_cen
//   x2_pxl       input pixel, sampled on basex2_cen
//   base_pxl     output pixel, updated one clk after base_cen
//   base_lstart  high while base_pxl holds pixel 0 of an output line
module jtframe_scanhalf #(
    parameter int DW   = 12,
    parameter int HLEN = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          base_cen,
    input  logic          basex2_cen,
    input  logic          blend_en,
    input  logic          x2_lstart,
    input  logic [DW-1:0] x2_pxl,
    output logic [DW-1:0] base_pxl,
    output logic          base_lstart
);

    localparam int AW    = (HLEN <= 256) ? 8 : ((HLEN <= 512) ? 9 : 10);
    localparam int CW    = DW / 3;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST = AW'(HLEN - 1);
    localparam logic [AW-1:0] ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ONE  = AW'(1);

    // Per-channel floor average; the extra sum bit keeps carries inside each channel.
    function automatic logic [DW-1:0] blend_px(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [CW:0]   s;
        r = {DW{1'b0}};
        for (int c = 0; c < 3; c++) begin
            s = {1'b0, a[c*CW +: CW]} + {1'b0, b[c*CW +: CW]};
            r[c*CW +: CW] = s[CW:1];
        end
        return r;
    endfunction

    // Bank depth rounds up to the full address space so every address is in range.
    logic [DW-1:0] mem [0:1][0:DEPTH-1];

    logic [AW-1:0] wraddr_q, wraddr_d;
    logic [AW-1:0] rdaddr_q, rdaddr_d;
    logic          half_q, half_d;
    logic          wrbank_q, wrbank_d;
    logic          rdbank_q, rdbank_d;
    logic [DW-1:0] base_pxl_q, base_pxl_d;
    logic          base_lstart_q, base_lstart_d;

    logic          early_wrap;
    logic          eff_half;
    logic          eff_bank;
    logic [AW-1:0] eff_addr;
    logic [DW-1:0] old_pxl;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_bank;

    // Write side: address/half/bank sequencing and the read-modify-write blend.
    always_comb begin
        wraddr_d = wraddr_q;
        half_d   = half_q;
        wrbank_d = wrbank_q;
        wr_en    = 1'b0;
        wr_bank  = wrbank_q;
        wr_addr  = wraddr_q;
        wr_data  = x2_pxl;
        // A line-start mid-line acts like a wrap taken before this pixel, so the
        // pixel goes to address 0 of the following line.
        early_wrap = x2_lstart && (wraddr_q != ZERO);
        eff_half   = early_wrap ? ~half_q : half_q;
        eff_bank   = (early_wrap && half_q) ? ~wrbank_q : wrbank_q;
        eff_addr   = early_wrap ? ZERO : wraddr_q;
        old_pxl    = mem[eff_bank][eff_addr];
        if (basex2_cen) begin
            wr_bank = eff_bank;
            wr_addr = eff_addr;
            if (eff_half) begin
                wr_en   = blend_en;
                wr_data = blend_px(old_pxl, x2_pxl);
            end else begin
                wr_en   = 1'b1;
                wr_data = x2_pxl;
            end
            if (early_wrap) begin
                wraddr_d = ONE;
                half_d   = eff_half;
                wrbank_d = eff_bank;
            end else if (wraddr_q == LAST) begin
                wraddr_d = ZERO;
                half_d   = ~half_q;
                wrbank_d = half_q ? ~wrbank_q : wrbank_q;
            end else begin
                wraddr_d = wraddr_q + ONE;
            end
        end else begin
            wr_en = 1'b0;
        end
    end

    // Read side: the bank is chosen only at pixel 0 so a line never tears.
    always_comb begin
        rdaddr_d      = rdaddr_q;
        rdbank_d      = rdbank_q;
        base_pxl_d    = base_pxl_q;
        base_lstart_d = base_lstart_q;
        rd_bank       = (rdaddr_q == ZERO) ? ~wrbank_q : rdbank_q;
        if (base_cen) begin
            rdbank_d      = rd_bank;
            base_pxl_d    = mem[rd_bank][rdaddr_q];
            base_lstart_d = (rdaddr_q == ZERO);
            rdaddr_d      = (rdaddr_q == LAST) ? ZERO : (rdaddr_q + ONE);
        end else begin
            rdbank_d = rdbank_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wraddr_q      <= ZERO;
            rdaddr_q      <= ZERO;
            half_q        <= 1'b0;
            wrbank_q      <= 1'b0;
            rdbank_q      <= 1'b1;
            base_pxl_q    <= {DW{1'b0}};
            base_lstart_q <= 1'b0;
        end else begin
            wraddr_q      <= wraddr_d;
            rdaddr_q      <= rdaddr_d;
            half_q        <= half_d;
            wrbank_q      <= wrbank_d;
            rdbank_q      <= rdbank_d;
            base_pxl_q    <= base_pxl_d;
            base_lstart_q <= base_lstart_d;
        end
    end

    // Line storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign base_pxl    = base_pxl_q;
    assign base_lstart = base_lstart_q;

endmodule

// File: tb/tb_jtframe_scanhalf.sv
// Directed bench for jtframe_scanhalf with HLEN=4, DW=12.
module tb_jtframe_scanhalf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        base_cen = 1'b0;
    logic        basex2_cen = 1'b0;
    logic        blend_en = 1'b0;
    logic        x2_lstart = 1'b0;
    logic [11:0] x2_pxl = 12'h000;
    logic [11:0] base_pxl;
    logic        base_lstart;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] data [0:10][0:1][0:3];

    jtframe_scanhalf #(.DW(12), .HLEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .base_cen   (base_cen),
        .basex2_cen (basex2_cen),
        .blend_en   (blend_en),
        .x2_lstart  (x2_lstart),
        .x2_pxl     (x2_pxl),
        .base_pxl   (base_pxl),
        .base_lstart(base_lstart)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clk with the given strobes; outputs are stable on return.
    task automatic cyc(input logic bc, input logic xc, input logic ls, input logic [11:0] px);
        base_cen   = bc;
        basex2_cen = xc;
        x2_lstart  = ls;
        x2_pxl     = px;
        @(posedge clk);
        #1;
        base_cen   = 1'b0;
        basex2_cen = 1'b0;
        x2_lstart  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        rst = 1'b0;
    endtask

    function automatic logic [11:0] ref_avg(input logic [11:0] a, input logic [11:0] b);
        logic [4:0] r, g, bl;
        r  = {1'b0, a[11:8]} + {1'b0, b[11:8]};
        g  = {1'b0, a[7:4]}  + {1'b0, b[7:4]};
        bl = {1'b0, a[3:0]}  + {1'b0, b[3:0]};
        return {r[4:1], g[4:1], bl[4:1]};
    endfunction

    initial begin
        logic [11:0] a_line [0:3];
        logic [11:0] b_line [0:3];
        logic [11:0] e_line [0:3];
        a_line = '{12'hF0F, 12'hFFF, 12'h000, 12'h123};
        b_line = '{12'h0F1, 12'hFFF, 12'h000, 12'h321};
        e_line = '{12'h778, 12'hFFF, 12'h000, 12'h123};

        // Reset state
        do_reset();
        check_eq("rst_pxl", 32'(base_pxl), 32'h000);
        check_eq("rst_lstart", 32'(base_lstart), 32'h0);

        // 1: blend off keeps the first line of the pair
        blend_en = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'h111);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'h222);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 12'h000);
            check_eq($sformatf("keep_pxl%0d", i), 32'(base_pxl), 32'h111);
            check_eq($sformatf("keep_ls%0d", i), 32'(base_lstart), (i == 0) ? 32'h1 : 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        check_eq("hold_pxl", 32'(base_pxl), 32'h111);

        // 2: per-channel average, no channel carry, blend_en sampled per pixel
        do_reset();
        blend_en = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, a_line[i]);
        for (int i = 0; i < 4; i++) begin
            blend_en = (i != 3);
            cyc(1'b0, 1'b1, 1'b0, b_line[i]);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 12'h000);
            check_eq($sformatf("blend_pxl%0d", i), 32'(base_pxl), 32'(e_line[i]));
        end

        // 4: x2_lstart mid-line and at address 0
        do_reset();
        blend_en = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 12'h100);
        cyc(1'b0, 1'b1, 1'b0, 12'h200);
        cyc(1'b0, 1'b1, 1'b1, 12'h300);
        cyc(1'b0, 1'b1, 1'b0, 12'h400);
        blend_en = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 12'h500);
        cyc(1'b0, 1'b1, 1'b0, 12'h600);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        check_eq("lstart_a0", 32'(base_pxl), 32'h200);
        check_eq("lstart_a0_ls", 32'(base_lstart), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        check_eq("lstart_a1", 32'(base_pxl), 32'h300);
        blend_en = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 12'hA00);
        cyc(1'b0, 1'b1, 1'b0, 12'hB00);
        cyc(1'b0, 1'b1, 1'b0, 12'hC00);
        cyc(1'b0, 1'b1, 1'b0, 12'hD00);
        blend_en = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'hEEE);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 12'h000);
            check_eq($sformatf("lstart0_pxl%0d", i), 32'(base_pxl), 32'hA00 + 32'(i) * 32'h100);
        end

        // 5: reset mid-line
        do_reset();
        blend_en = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'hABC);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        check_eq("pre_rst_pxl", 32'(base_pxl), 32'hABC);
        cyc(1'b0, 1'b1, 1'b0, 12'h777);
        cyc(1'b0, 1'b1, 1'b0, 12'h777);
        do_reset();
        check_eq("mid_rst_pxl", 32'(base_pxl), 32'h000);
        check_eq("mid_rst_ls", 32'(base_lstart), 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'h555);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'h666);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 12'h000);
            check_eq($sformatf("resume_pxl%0d", i), 32'(base_pxl), 32'h555);
            check_eq($sformatf("resume_ls%0d", i), 32'(base_lstart), (i == 0) ? 32'h1 : 32'h0);
        end

        // 3 + 6: free-running stream, base_cen on every 2nd basex2_cen
        for (int p = 0; p < 11; p++)
            for (int h = 0; h < 2; h++)
                for (int a = 0; a < 4; a++)
                    data[p][h][a] = 12'($urandom_range(0, 4095));
        do_reset();
        blend_en = 1'b1;
        for (int t = 0; t < 88; t++) begin
            int p, h, a, n, ra;
            logic bc;
            p  = t / 8;
            h  = (t / 4) % 2;
            a  = t % 4;
            bc = ((t % 2) == 0);
            cyc(bc, 1'b1, 1'b0, data[p][h][a]);
            if (bc && (t >= 8)) begin
                n  = t / 8;
                ra = (t % 8) / 2;
                check_eq($sformatf("stream_l%0d_p%0d", n, ra), 32'(base_pxl),
                         32'(ref_avg(data[n-1][0][ra], data[n-1][1][ra])));
                check_eq($sformatf("stream_ls_l%0d_p%0d", n, ra), 32'(base_lstart),
                         (ra == 0) ? 32'h1 : 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
